// File: rtl/adder_seq_pkg.sv
// Shared types and defaults for the adder operand sequencer.
package adder_seq_pkg;

  localparam int unsigned WIDTH_DEF       = 8;
  localparam int unsigned PATTERN_NUM_DEF = 10;
  localparam int unsigned CNT_W_DEF       = 16;

  // Sequencer phase: load x, load y, let the adder settle, present result.
  typedef enum logic [1:0] {
    S_X    = 2'd0,
    S_Y    = 2'd1,
    S_EVAL = 2'd2,
    S_OUT  = 2'd3
  } state_e;

endpackage : adder_seq_pkg

// File: rtl/adder_gate.sv
// Combinational ripple-carry adder that sits beside the sequencer.
// Ports:
//   x, y   in   WIDTH  operands
//   out    out  WIDTH  sum bits
//   carry  out  1      carry out of the MSB
module adder_gate
  import adder_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] out,
  output logic             carry
);

  // Bit-serial carry chain, LSB first.
  always_comb begin
    logic cy;
    cy  = 1'b0;
    out = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      out[i] = x[i] ^ y[i] ^ cy;
      cy     = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
    end
    carry = cy;
  end

endmodule : adder_gate

// File: rtl/adder_operand_sequencer.sv
// Feeds byte pairs from a valid/ready stream into an external combinational
// adder, captures {carry,sum} after one settle cycle and returns it over a
// valid/ready result port while counting completed result handshakes.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     in   upstream byte valid
//   in_ready     out  upstream byte accepted this cycle (decoded from state)
//   in_data      in   operand byte; first of a pair is x, second is y
//   x, y         out  registered operands to the adder
//   sum_in       in   adder sum
//   carry_in     in   adder carry
//   res_valid    out  res_data valid
//   res_ready    in   consumer takes res_data
//   res_data     out  {carry,sum} captured result
//   pair_cnt     out  completed result handshakes (wraps)
//   done         out  sticky, pair_cnt has reached PATTERN_NUM
module adder_operand_sequencer
  import adder_seq_pkg::*;
#(
  parameter int unsigned WIDTH       = WIDTH_DEF,
  parameter int unsigned PATTERN_NUM = PATTERN_NUM_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             carry_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH:0]   res_data,
  output logic [CNT_W-1:0] pair_cnt,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH:0]   res_data_q, res_data_d;
  logic             res_valid_q, res_valid_d;
  logic [CNT_W-1:0] pair_cnt_q, pair_cnt_d;
  logic             done_q, done_d;

  // Ready only in the load phases; gated by rst_n so it reads 0 during reset.
  assign in_ready = rst_n && ((state_q == S_X) || (state_q == S_Y));

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    pair_cnt_d  = pair_cnt_q;
    done_d      = done_q;

    unique case (state_q)
      S_X: begin
        if (in_valid) begin
          x_d     = in_data;
          state_d = S_Y;
        end
      end
      S_Y: begin
        if (in_valid) begin
          y_d     = in_data;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        // x/y have been stable for a full cycle, so the adder output is settled.
        res_data_d  = {carry_in, sum_in};
        res_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          pair_cnt_d  = pair_cnt_q + CNT_W'(1);
          if (pair_cnt_d == CNT_W'(PATTERN_NUM)) begin
            done_d = 1'b1;
          end
          state_d = S_X;
        end
      end
      default: state_d = S_X;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_X;
      x_q         <= '0;
      y_q         <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      pair_cnt_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      pair_cnt_q  <= pair_cnt_d;
      done_q      <= done_d;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign pair_cnt  = pair_cnt_q;
  assign done      = done_q;

endmodule : adder_operand_sequencer

// File: tb/tb_adder_operand_sequencer.sv
// Bench for adder_operand_sequencer: two instances (16-bit and 4-bit pair
// counters) share one stimulus stream, each beside its own adder_gate.
module tb_adder_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       res_ready = 1'b0;

  logic        in_ready_a, carry_a, res_valid_a, done_a;
  logic [7:0]  x_a, y_a, sum_a;
  logic [8:0]  res_data_a;
  logic [15:0] pair_cnt_a;

  logic        in_ready_b, carry_b, res_valid_b, done_b;
  logic [7:0]  x_b, y_b, sum_b;
  logic [8:0]  res_data_b;
  logic [3:0]  pair_cnt_b;

  always #5 clk = ~clk;

  adder_gate #(.WIDTH(8)) u_add_a (.x(x_a), .y(y_a), .out(sum_a), .carry(carry_a));
  adder_gate #(.WIDTH(8)) u_add_b (.x(x_b), .y(y_b), .out(sum_b), .carry(carry_b));

  adder_operand_sequencer #(.WIDTH(8), .PATTERN_NUM(10), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .x(x_a), .y(y_a), .sum_in(sum_a), .carry_in(carry_a),
    .res_valid(res_valid_a), .res_ready(res_ready), .res_data(res_data_a),
    .pair_cnt(pair_cnt_a), .done(done_a));

  adder_operand_sequencer #(.WIDTH(8), .PATTERN_NUM(10), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .x(x_b), .y(y_b), .sum_in(sum_b), .carry_in(carry_b),
    .res_valid(res_valid_b), .res_ready(res_ready), .res_data(res_data_b),
    .pair_cnt(pair_cnt_b), .done(done_b));

  int compared   = 0;
  int mismatched = 0;

  // Reference model: total handshakes since reset, and sticky done flags.
  int total      = 0;
  bit exp_done_a = 1'b0;
  bit exp_done_b = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_handshake();
    total++;
    if ((total % 65536) == 10) exp_done_a = 1'b1;
    if ((total % 16) == 10)    exp_done_b = 1'b1;
  endtask

  task automatic model_reset();
    total      = 0;
    exp_done_a = 1'b0;
    exp_done_b = 1'b0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, " pair_cnt_a"}, 32'(pair_cnt_a), 32'(total % 65536));
    chk({tag, " pair_cnt_b"}, 32'(pair_cnt_b), 32'(total % 16));
    chk({tag, " done_a"}, 32'(done_a), 32'(exp_done_a));
    chk({tag, " done_b"}, 32'(done_b), 32'(exp_done_b));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " in_ready"}, 32'({in_ready_a, in_ready_b}), 32'd0);
    chk({tag, " x"}, 32'({x_a, x_b}), 32'd0);
    chk({tag, " y"}, 32'({y_a, y_b}), 32'd0);
    chk({tag, " res_data"}, 32'({res_data_a, res_data_b}), 32'd0);
    chk({tag, " res_valid"}, 32'({res_valid_a, res_valid_b}), 32'd0);
    check_status(tag);
  endtask

  // Offer one byte until accepted; with rnd, in_valid is randomly withheld.
  task automatic push(input logic [7:0] b, input bit rnd, input string tag);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 64) begin
      @(negedge clk);
      if (rnd && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = b;
        acc      = in_ready_a;
      end
      n++;
    end
    chk({tag, " accepted"}, 32'(acc), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // One full pair: load, settle, result with 'hold' stall cycles, handshake.
  task automatic do_pair(input logic [7:0] a, input logic [7:0] b, input bit rnd,
                         input int hold, input logic [7:0] junk, input string tag);
    int exp_res;
    exp_res = int'(a) + int'(b);
    push(a, rnd, {tag, " x"});
    chk({tag, " x loaded"}, 32'({x_a, x_b}), 32'({a, a}));
    push(b, rnd, {tag, " y"});
    chk({tag, " y loaded"}, 32'({y_a, y_b}), 32'({b, b}));
    chk({tag, " no early valid"}, 32'({res_valid_a, res_valid_b}), 32'd0);
    chk({tag, " eval in_ready"}, 32'({in_ready_a, in_ready_b}), 32'd0);
    // Source presents a byte that must not be consumed until the pair completes.
    in_valid  = 1'b1;
    in_data   = junk;
    res_ready = (hold == 0);
    @(posedge clk);
    #1;
    chk({tag, " res_valid"}, 32'({res_valid_a, res_valid_b}), 32'b11);
    chk({tag, " res_data_a"}, 32'(res_data_a), 32'(exp_res));
    chk({tag, " res_data_b"}, 32'(res_data_b), 32'(exp_res));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk({tag, " stall valid"}, 32'({res_valid_a, res_valid_b}), 32'b11);
      chk({tag, " stall data"}, 32'(res_data_a), 32'(exp_res));
      chk({tag, " stall in_ready"}, 32'({in_ready_a, in_ready_b}), 32'd0);
      chk({tag, " stall x held"}, 32'({x_a, x_b}), 32'({a, a}));
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    model_handshake();
    chk({tag, " valid dropped"}, 32'({res_valid_a, res_valid_b}), 32'd0);
    chk({tag, " data held"}, 32'(res_data_a), 32'(exp_res));
    check_status(tag);
    in_valid  = 1'b0;
    res_ready = 1'b0;
  endtask

  logic [7:0] ga, gb;

  initial begin
    // Reset state, then release.
    repeat (2) @(negedge clk);
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release in_ready", 32'({in_ready_a, in_ready_b}), 32'b11);

    // Basic pair.
    do_pair(8'h12, 8'h34, 1'b0, 0, 8'h00, "t1");
    // Carry out cases.
    do_pair(8'hFF, 8'h01, 1'b0, 0, 8'h00, "t2a");
    do_pair(8'hFF, 8'hFF, 1'b0, 0, 8'h00, "t2b");
    // Long consumer stall; held source byte becomes the next x.
    do_pair(8'h80, 8'h80, 1'b0, 5, 8'hAA, "t3");
    do_pair(8'hAA, 8'h11, 1'b0, 0, 8'h00, "t3next");

    // Reset with half a pair loaded.
    push(8'h55, 1'b0, "t5 x");
    chk("t5 x loaded", 32'(x_a), 32'h55);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset("t5 reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t5 release in_ready", 32'({in_ready_a, in_ready_b}), 32'b11);
    do_pair(8'h01, 8'h02, 1'b0, 0, 8'h00, "t5 pair");

    // Random operands, random valid gaps and result stalls; done at 10.
    model_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ga = 8'($urandom);
      gb = 8'($urandom);
      do_pair(ga, gb, 1'b1, int'($urandom_range(0, 3)), 8'($urandom), $sformatf("t4 p%0d", i));
    end
    chk("t4 done sticky", 32'({done_a, done_b}), 32'b11);

    // Seven more pairs: 17 total, 4-bit counter wraps to 1.
    for (int i = 0; i < 7; i++) begin
      ga = 8'($urandom);
      gb = 8'($urandom);
      do_pair(ga, gb, 1'b0, int'($urandom_range(0, 1)), 8'($urandom), $sformatf("t6 p%0d", i));
    end
    chk("t6 wrap cnt_b", 32'(pair_cnt_b), 32'd1);
    chk("t6 cnt_a", 32'(pair_cnt_a), 32'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule : tb_adder_operand_sequencer
